// File: rtl/vshift_seq.sv
// vshift_seq: chunk sequencer for vector shift instructions.
//
// Walks a vs2 operand of 1..8 64-bit chunks, feeds each chunk and the
// matching vs1 shift amounts to an external combinational shifter, and
// streams the results out through a valid/ready output register.
//
// Encodings:
//   instr_type: 3'd0 VSLL, 3'd1 VSRL, 3'd2 VSRA, 3'd3 VNSRL, 3'd4 VNSRA
//   sew       : 2'd0 SEW_8, 2'd1 SEW_16, 2'd2 SEW_32, 2'd3 SEW_64
//
// Build option: define VSHIFT_SEQ_NARROW_EN to support the narrowing shifts
// (VNSRL/VNSRA). Without it the pack logic is absent and narrowing requests
// are rejected as illegal.
module vshift_seq (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  instr_type_i,
  input  logic [1:0]  sew_i,
  input  logic [3:0]  nchunks_i,
  output logic        rd_valid_o,
  output logic [2:0]  rd_vs2_idx_o,
  output logic [2:0]  rd_vs1_idx_o,
  input  logic [63:0] rd_vs1_i,
  input  logic [63:0] rd_vs2_i,
  output logic [2:0]  sh_instr_type_o,
  output logic [1:0]  sh_sew_o,
  output logic [63:0] sh_vs1_o,
  output logic [63:0] sh_vs2_o,
  input  logic [63:0] sh_vd_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [63:0] res_data_o,
  output logic [2:0]  res_idx_o,
  output logic        res_last_o,
  output logic        busy_o,
  output logic        illegal_o
);

  localparam logic [2:0] VSLL   = 3'd0;
  localparam logic [2:0] VSRL   = 3'd1;
  localparam logic [2:0] VSRA   = 3'd2;
  localparam logic [2:0] VNSRL  = 3'd3;
  localparam logic [2:0] VNSRA  = 3'd4;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Narrowing shifts consume two vs2 chunks per destination word.
  function automatic logic is_narrow(input logic [2:0] t);
    return (t == VNSRL) || (t == VNSRA);
  endfunction

  // A request is accepted only with a known opcode, 1..8 chunks, and a
  // narrowing destination width that leaves room for a 2*SEW source.
  function automatic logic req_is_legal(input logic [2:0] t,
                                        input logic [1:0] sew,
                                        input logic [3:0] n);
    logic ok;
    ok = (t inside {VSLL, VSRL, VSRA, VNSRL, VNSRA}) &&
         (n != 4'd0) && (n <= 4'd8) &&
         !(is_narrow(t) && (sew == SEW_64));
`ifndef VSHIFT_SEQ_NARROW_EN
    ok = ok && !is_narrow(t);
`endif
    return ok;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  instr_q, instr_d;
  logic [1:0]  sew_q, sew_d;
  logic [3:0]  nch_q, nch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        res_valid_q, res_valid_d;
  logic [63:0] res_data_q, res_data_d;
  logic [2:0]  res_idx_q, res_idx_d;
  logic        res_last_q, res_last_d;
  logic        illegal_q, illegal_d;
  logic        busy_q, busy_d;
  logic        rd_valid_q, rd_valid_d;
`ifdef VSHIFT_SEQ_NARROW_EN
  logic [31:0] pack_q, pack_d;
`endif

  logic        narrow_s;
  logic        adv_s;
  logic        last_chunk_s;

`ifdef VSHIFT_SEQ_NARROW_EN
  assign narrow_s = is_narrow(instr_q);
`else
  assign narrow_s = 1'b0;
`endif

  // The output register may take a new word when it is empty or being drained.
  assign adv_s        = !res_valid_q || res_ready_i;
  assign last_chunk_s = ({1'b0, cnt_q} == (nch_q - 4'd1));

  assign req_ready_o  = (state_q == ST_IDLE);
  assign rd_valid_o   = rd_valid_q;
  assign rd_vs2_idx_o = cnt_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_idx_o    = res_idx_q;
  assign res_last_o   = res_last_q;
  assign busy_o       = busy_q;
  assign illegal_o    = illegal_q;

  assign sh_instr_type_o = instr_q;
  assign sh_sew_o        = sew_q;
  assign sh_vs2_o        = rd_vs2_i;

  // Operand routing: narrowing reads one vs1 chunk for every two vs2 chunks,
  // odd vs2 chunks use the upper half of that vs1 chunk moved down.
  always_comb begin
    rd_vs1_idx_o = cnt_q;
    sh_vs1_o     = rd_vs1_i;
    if (narrow_s) begin
      rd_vs1_idx_o = {1'b0, cnt_q[2:1]};
      sh_vs1_o     = cnt_q[0] ? {32'd0, rd_vs1_i[63:32]} : rd_vs1_i;
    end else begin
      rd_vs1_idx_o = cnt_q;
      sh_vs1_o     = rd_vs1_i;
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    sew_d       = sew_q;
    nch_d       = nch_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q && !res_ready_i;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    res_last_d  = res_last_q;
    illegal_d   = 1'b0;
`ifdef VSHIFT_SEQ_NARROW_EN
    pack_d      = pack_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_is_legal(instr_type_i, sew_i, nchunks_i)) begin
            instr_d = instr_type_i;
            sew_d   = sew_i;
            nch_d   = nchunks_i;
            cnt_d   = 3'd0;
`ifdef VSHIFT_SEQ_NARROW_EN
            pack_d  = 32'd0;
`endif
            state_d = ST_RUN;
          end else begin
            illegal_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (adv_s) begin
          cnt_d   = cnt_q + 3'd1;
          state_d = last_chunk_s ? ST_DRAIN : ST_RUN;
`ifdef VSHIFT_SEQ_NARROW_EN
          if (narrow_s) begin
            if (cnt_q[0]) begin
              // Odd chunk completes a packed word.
              res_valid_d = 1'b1;
              res_data_d  = {sh_vd_i[31:0], pack_q};
              res_idx_d   = {1'b0, cnt_q[2:1]};
              res_last_d  = last_chunk_s;
            end else if (last_chunk_s) begin
              // Lone trailing even chunk: emit with an empty upper half.
              res_valid_d = 1'b1;
              res_data_d  = {32'd0, sh_vd_i[31:0]};
              res_idx_d   = {1'b0, cnt_q[2:1]};
              res_last_d  = 1'b1;
            end else begin
              pack_d = sh_vd_i[31:0];
            end
          end else begin
            res_valid_d = 1'b1;
            res_data_d  = sh_vd_i;
            res_idx_d   = cnt_q;
            res_last_d  = last_chunk_s;
          end
`else
          res_valid_d = 1'b1;
          res_data_d  = sh_vd_i;
          res_idx_d   = cnt_q;
          res_last_d  = last_chunk_s;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (res_valid_q && res_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    rd_valid_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      instr_q     <= 3'd0;
      sew_q       <= 2'd0;
      nch_q       <= 4'd0;
      cnt_q       <= 3'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 64'd0;
      res_idx_q   <= 3'd0;
      res_last_q  <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
`ifdef VSHIFT_SEQ_NARROW_EN
      pack_q      <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      sew_q       <= sew_d;
      nch_q       <= nch_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_last_q  <= res_last_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
`ifdef VSHIFT_SEQ_NARROW_EN
      pack_q      <= pack_d;
`endif
    end
  end

endmodule
